// File: rtl/mem_sched_pkg.sv
// Shared types, sizes and lane helper for the mem_read_sched data-memory read scheduler.
package mem_sched_pkg;

    localparam int NCORES     = 4;
    localparam int DW         = 16;
    localparam int WORD_W     = 64;
    localparam int LANE_SEL_W = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        DELIVER = 2'd3
    } state_t;

    // Lane 0 is the most significant element of the 64-bit memory word.
    function automatic logic [DW-1:0] lane_extract(input logic [WORD_W-1:0] word,
                                                   input logic [LANE_SEL_W-1:0] lane);
        logic [DW-1:0] elem;
        case (lane)
            2'd0:    elem = word[63:48];
            2'd1:    elem = word[47:32];
            2'd2:    elem = word[31:16];
            default: elem = word[15:0];
        endcase
        return elem;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request bit at or after ptr, modulo 4.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] grant,
    output logic [1:0] idx
);

    logic       found;
    logic [1:0] cand;

    always_comb begin
        grant = 4'b0000;
        idx   = 2'd0;
        found = 1'b0;
        cand  = 2'd0;
        for (int k = 0; k < 4; k++) begin
            cand = ptr + 2'(k);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/mem_read_sched.sv
// Shares one 64-bit memory read port among four 16-bit core load ports in round-robin order.
// Same-word coalescing is built only when MEM_READ_SCHED_COALESCE_EN is defined.
module mem_read_sched
    import mem_sched_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [3:0]  REQ,
    input  logic [63:0] ADDR,
    output logic        MEMREAD,
    output logic [15:0] MEMADDR,
    input  logic [63:0] MEMDATA,
    output logic [63:0] DOUT,
    output logic [3:0]  DVALID,
    output logic        BUSY,
    output logic [1:0]  dbg_state
);

    state_t state;
    state_t state_next;

    logic [1:0]           rr_ptr;
    logic [1:0]           win_q;
    logic [3:0]           lat_cnt;
    logic [3:0]           served;
    logic [13:0]          word_addr;
    logic [7:0]           lanes;
    logic [3:0]           grant;
    logic [1:0]           win_idx;
    logic [3:0]           serve_mask;
    logic [13:0]          win_word;
    logic [3:0][DW-1:0]   core_addr;

    assign core_addr = ADDR;
    assign win_word  = core_addr[win_idx][15:2];

    rr_pick4 u_pick (
        .req   (REQ),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (win_idx)
    );

`ifdef MEM_READ_SCHED_COALESCE_EN
    always_comb begin
        serve_mask = grant;
        for (int j = 0; j < NCORES; j++) begin
            if (REQ[j] && (core_addr[j][15:2] == win_word)) begin
                serve_mask[j] = 1'b1;
            end
        end
    end
`else
    assign serve_mask = grant;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        MEMREAD    = 1'b0;
        DVALID     = 4'b0000;
        BUSY       = 1'b1;
        case (state)
            IDLE: begin
                BUSY = 1'b0;
                if (REQ != 4'b0000) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                MEMREAD    = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (lat_cnt == 4'd1) begin
                    state_next = DELIVER;
                end
            end
            DELIVER: begin
                DVALID     = served;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Returned lanes are written on the WAIT->DELIVER edge so DOUT is valid alongside DVALID.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rr_ptr    <= 2'd0;
            win_q     <= 2'd0;
            lat_cnt   <= 4'd0;
            served    <= 4'b0000;
            word_addr <= 14'd0;
            lanes     <= 8'd0;
            DOUT      <= 64'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (REQ != 4'b0000) begin
                        served    <= serve_mask;
                        word_addr <= win_word;
                        win_q     <= win_idx;
                        for (int i = 0; i < NCORES; i++) begin
                            lanes[2*i +: 2] <= core_addr[i][1:0];
                        end
                    end
                end
                ISSUE: lat_cnt <= 4'(MEM_LAT);
                WAIT: begin
                    lat_cnt <= lat_cnt - 4'd1;
                    if (lat_cnt == 4'd1) begin
                        for (int i = 0; i < NCORES; i++) begin
                            if (served[i]) begin
                                DOUT[16*i +: 16] <= lane_extract(MEMDATA, lanes[2*i +: 2]);
                            end
                        end
                    end
                end
                DELIVER: rr_ptr <= win_q + 2'd1;
                default: ;
            endcase
        end
    end

    assign MEMADDR   = {2'b00, word_addr};
    assign dbg_state = state;

endmodule

// File: tb/tb_mem_read_sched.sv
// Directed bench for mem_read_sched: expected reads/deliveries are queued by the stimulus
// and popped by an independent monitor; MEM_LAT is fixed at 2.
module tb_mem_read_sched;
    import mem_sched_pkg::*;

    localparam int LAT = 2;
    localparam logic [63:0] GARBAGE = 64'hDEAD_BEEF_DEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = 4'b0000;
    logic [63:0] addr = 64'd0;
    logic        memread;
    logic [15:0] memaddr;
    logic [63:0] memdata = GARBAGE;
    logic [63:0] dout;
    logic [3:0]  dvalid;
    logic        busy;
    logic [1:0]  dbg_state;

    logic [63:0] mem [16];
    logic [15:0] rd_addr = 16'd0;
    int          rd_cnt = 0;
    logic [3:0]  rereq = 4'b0000;

    logic [15:0] exp_rd_q[$];
    logic [67:0] exp_dv_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;

    mem_read_sched #(.MEM_LAT(LAT)) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .REQ       (req),
        .ADDR      (addr),
        .MEMREAD   (memread),
        .MEMADDR   (memaddr),
        .MEMDATA   (memdata),
        .DOUT      (dout),
        .DVALID    (dvalid),
        .BUSY      (busy),
        .dbg_state (dbg_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    // Memory model: data is valid only in the cycle MEM_LAT after the MEMREAD cycle.
    always @(negedge clk) begin
        memdata = GARBAGE;
        if (rd_cnt != 0) begin
            rd_cnt = rd_cnt - 1;
            if (rd_cnt == 0) memdata = mem[rd_addr[3:0]];
        end
        if (memread) begin
            rd_addr = memaddr;
            rd_cnt  = LAT;
        end
    end

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin : monitor
        logic [67:0] e;
        if (rst_n) begin
            if (memread) begin
                if (exp_rd_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL memaddr: got unexpected MEMREAD addr %0h, expected no read", memaddr);
                end else begin
                    e = 68'(exp_rd_q.pop_front());
                    check("memaddr", 68'(memaddr), e);
                end
            end
            if (dvalid != 4'b0000) begin
                if (exp_dv_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL deliver: got unexpected DVALID %b DOUT %0h, expected none", dvalid, dout);
                end else begin
                    e = exp_dv_q.pop_front();
                    check("dvalid_dout", {dvalid, dout}, e);
                end
            end
        end
    end

    // Driver tasks
    task automatic check_reset_outputs(input string tag);
        check({tag, "_memread"}, 68'(memread), 68'(0));
        check({tag, "_memaddr"}, 68'(memaddr), 68'(0));
        check({tag, "_dout"},    68'(dout),    68'(0));
        check({tag, "_dvalid"},  68'(dvalid),  68'(0));
        check({tag, "_busy"},    68'(busy),    68'(0));
        check({tag, "_state"},   68'(dbg_state), 68'(IDLE));
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'b0000;
        rereq = 4'b0000;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic issue(input logic [3:0] r, input logic [63:0] a);
        @(negedge clk);
        addr = a;
        req  = r;
    endtask

    // Acts as the cores' handshake: drops REQ after DVALID unless a re-request is armed.
    task automatic wait_done(input int exp_lat);
        int k = 0;
        bit seen = 1'b0;
        bit done = 1'b0;
        while (!done && k < 200) begin
            @(negedge clk);
            k++;
            if (dvalid != 4'b0000) begin
                if (!seen && exp_lat != 0) check("latency", 68'(k), 68'(exp_lat));
                seen = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    if (dvalid[i]) begin
                        if (rereq[i]) rereq[i] = 1'b0;
                        else req[i] = 1'b0;
                    end
                end
            end
            done = (exp_rd_q.size() == 0) && (exp_dv_q.size() == 0) && !busy && (req == 4'b0000);
        end
        check("done_in_budget", 68'(done), 68'(1));
    endtask

    initial begin : main
        logic [15:0] lane_vals [4];
        lane_vals = '{16'h000D, 16'h000E, 16'h000F, 16'h0010};

        for (int i = 0; i < 16; i++) mem[i] = 64'h0;
        mem[0] = 64'h0001_0005_0009_000D;
        mem[1] = 64'h0001_0002_0003_0004;
        mem[2] = 64'h0011_0012_0013_0014;
        mem[3] = 64'h0021_0022_0023_0024;
        mem[4] = 64'h0031_0032_0033_0034;
        mem[7] = 64'h000D_000E_000F_0010;

        // Single request, word 1 lane 1
        apply_reset();
        exp_rd_q.push_back(16'h0001);
        exp_dv_q.push_back({4'b0001, 64'h0000_0000_0000_0002});
        issue(4'b0001, 64'h0000_0000_0000_0005);
        wait_done(4);

        // All four cores on word 0 (lanes 0,0,1,1)
        apply_reset();
`ifdef MEM_READ_SCHED_COALESCE_EN
        exp_rd_q.push_back(16'h0000);
        exp_dv_q.push_back({4'b1111, 64'h0005_0005_0001_0001});
`else
        for (int i = 0; i < 4; i++) exp_rd_q.push_back(16'h0000);
        exp_dv_q.push_back({4'b0001, 64'h0000_0000_0000_0001});
        exp_dv_q.push_back({4'b0010, 64'h0000_0000_0001_0001});
        exp_dv_q.push_back({4'b0100, 64'h0000_0005_0001_0001});
        exp_dv_q.push_back({4'b1000, 64'h0005_0005_0001_0001});
`endif
        issue(4'b1111, 64'h0001_0001_0000_0000);
        wait_done(4);

        // Round-robin over words 1..4 lane 3; core0 re-requests right after its DVALID
        apply_reset();
        exp_rd_q.push_back(16'h0001);
        exp_rd_q.push_back(16'h0002);
        exp_rd_q.push_back(16'h0003);
        exp_rd_q.push_back(16'h0004);
        exp_rd_q.push_back(16'h0001);
        exp_dv_q.push_back({4'b0001, 64'h0000_0000_0000_0004});
        exp_dv_q.push_back({4'b0010, 64'h0000_0000_0014_0004});
        exp_dv_q.push_back({4'b0100, 64'h0000_0024_0014_0004});
        exp_dv_q.push_back({4'b1000, 64'h0034_0024_0014_0004});
        exp_dv_q.push_back({4'b0001, 64'h0034_0024_0014_0004});
        rereq = 4'b0001;
        issue(4'b1111, 64'h0013_000F_000B_0007);
        wait_done(4);

        // Lane mapping: core2 walks the four lanes of word 7
        apply_reset();
        for (int v = 0; v < 4; v++) begin
            exp_rd_q.push_back(16'h0007);
            exp_dv_q.push_back({4'b0100, 16'h0000, lane_vals[v], 32'h0});
            issue(4'b0100, {16'h0000, 16'h001C + 16'(v), 32'h0});
            wait_done(4);
        end

        // Reset during WAIT aborts the read; RR pointer restarts at core0
        apply_reset();
        exp_rd_q.push_back(16'h0001);
        exp_dv_q.push_back({4'b0001, 64'h0000_0000_0000_0002});
        issue(4'b0001, 64'h0000_0000_0000_0005);
        wait_done(4);
        exp_rd_q.push_back(16'h0002);
        issue(4'b0010, 64'h0000_0000_0008_0005);
        @(negedge clk);
        @(negedge clk);
        check("state_before_abort", 68'(dbg_state), 68'(WAIT));
        rst_n = 1'b0;
        req   = 4'b0000;
        #1;
        check_reset_outputs("abort");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("abort_rd_q_empty", 68'(exp_rd_q.size()), 68'(0));
        exp_rd_q.push_back(16'h0001);
        exp_rd_q.push_back(16'h0002);
        exp_dv_q.push_back({4'b0001, 64'h0000_0000_0000_0002});
        exp_dv_q.push_back({4'b0010, 64'h0000_0000_0011_0002});
        issue(4'b0011, 64'h0000_0000_0008_0005);
        wait_done(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_read_sched.md
Name: mem_read_sched

Overview:
- Sequential scheduler that shares the single 64-bit data-memory read port between the four core load ports.
- Each core requests one 16-bit element. Byte-free element address: ADDR[15:2] is the memory word, ADDR[1:0] is the 16-bit lane.
- Requests to the same memory word are coalesced into one read. Distinct words are served in round-robin order.
- Sits between the core load ports and the data memory; replaces the purely combinational load fan-out.

Parameters:
- NCORES, 4, number of requesting cores (design and bench fixed at 4).
- DW, 16, element width; memory word width is 4*DW = 64.
- MEM_LAT, 1, cycles from the MEMREAD cycle to MEMDATA being valid; legal range 1..15.

Ports:
- CLK  in  1  single clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- REQ  in  4  per-core read request (level); bit i belongs to core i.
- ADDR  in  64  per-core element address; core i uses [16i+15:16i]. Must be stable while REQ[i]=1.
- MEMREAD  out  1  one-cycle memory read strobe.
- MEMADDR  out  16  word address, {2'b00, ADDR[15:2]} of the winning core.
- MEMDATA  in  64  memory read data; valid MEM_LAT cycles after MEMREAD.
- DOUT  out  64  per-core returned element; core i uses [16i+15:16i]. Holds its value until the core is next served.
- DVALID  out  4  one-cycle pulse per served core.
- BUSY  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous):
  - MEMREAD=0, MEMADDR=0, DOUT=0, DVALID=0, BUSY=0.
  - State=IDLE, RR_PTR=0, latency counter=0, served mask=0.
- Reset asserted mid-operation aborts the in-flight read. No DVALID is produced, and any MEMDATA that later returns is ignored.
- FSM states: IDLE, ISSUE, WAIT, DELIVER.
- IDLE:
  - If REQ==0, stay in IDLE.
  - Otherwise the winner w is the first set REQ bit searching RR_PTR, RR_PTR+1, ... modulo 4.
  - Served mask = winner bit plus every core j with REQ[j]=1 and ADDR_j[15:2]==ADDR_w[15:2].
  - Latch the word address and the served mask; go to ISSUE.
- ISSUE: MEMREAD=1 and MEMADDR valid for exactly this cycle. Load counter=MEM_LAT; go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle the counter reaches 1, capture MEMDATA (MEM_LAT cycles after ISSUE); go to DELIVER.
- DELIVER:
  - For each served core i, DOUT_i = lane ADDR_i[1:0] of the captured word.
  - Lane mapping: lane 0 = [63:48], lane 1 = [47:32], lane 2 = [31:16], lane 3 = [15:0].
  - DVALID = served mask for this one cycle; non-served DOUT lanes are unchanged.
  - RR_PTR = (w+1) mod 4; go to IDLE.
- Latency for a request sampled in IDLE at cycle 0: MEMREAD in cycle 1, DVALID in cycle 2+MEM_LAT. Minimum turnaround 3+MEM_LAT cycles per memory read.
- Handshake:
  - A core holds REQ until its DVALID, then must have REQ low in the following cycle.
  - REQ high in that cycle is a new request.
- A request raised after the IDLE sampling cycle is not added to the in-flight read; it waits for the next IDLE.
- Starvation-free: any pending core is served within 4 memory reads.
- Simultaneous identical addresses: all matching cores receive the same data in the same DVALID cycle.

Optional Feature:
- Macro: MEM_READ_SCHED_COALESCE_EN.
- Defined: behaviour exactly as above, with same-word requests merged.
- Undefined: served mask = winner bit only. Every request costs its own memory read, still in round-robin order, and the address comparators are not built.

Decomposition:
- Shared package mem_sched_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, DELIVER};
  - NCORES, DW, WORD_W=64, LANE_SEL_W=2;
  - a lane-extract function (word, lane) -> element.
- One sub-module, rr_pick4: 4-bit request vector plus 2-bit pointer in, one-hot grant plus 2-bit index out, purely combinational.

Test Plan:
- Single request: MEM_LAT=2, mem[1]=0x0001_0002_0003_0004, REQ=0001, ADDR0=0x0005 -> exactly one MEMREAD with MEMADDR=0x0001; DVALID=0001 in cycle 4; DOUT0=0x0002.
- Full coalescing: mem[0]=0x0001_0005_0009_000D, REQ=1111, ADDRs=0x0000,0x0000,0x0001,0x0001 -> one MEMREAD; DVALID=1111; DOUT=1,1,5,5. With the macro undefined -> four MEMREADs served in core order 0,1,2,3, with the same DOUT values.
- Round-robin: REQ=1111 with words 1,2,3,4 (lane 3) -> MEMADDR sequence 1,2,3,4. Core0 re-requests immediately after its DVALID -> it is served only after cores 1,2,3.
- Lane mapping: mem[7]=0x000D_000E_000F_0010, one core walks ADDR 0x001C..0x001F -> DOUT 0x000D, 0x000E, 0x000F, 0x0010.
- Reset mid-WAIT: assert RST_N=0 during WAIT -> all outputs 0 immediately and no DVALID after release. A fresh request after release is served with the nominal 2+MEM_LAT latency, and MEMADDR starts from RR_PTR=0.
